// File: rtl/ram_pkg.sv
// ram_pkg: command type, command-pin decode and default constants shared by ram_ctrl
package ram_pkg;
  typedef enum logic [2:0] {NOP, ACT, RD, WR, PRE, REF, MRS} cmd_e;
  localparam int BA_W_DEF = 2;
  localparam int ROW_W_DEF = 4;
  localparam int COL_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int CL_DEF_DEF = 3;
  localparam int TRCD_DEF = 2;
  localparam int TRFC_DEF = 4;
  localparam int PIPE_D = 5;
  function automatic int addr_w(input int row_w, input int col_w);
    int w;
    w = row_w > col_w + 1 ? row_w : col_w + 1;
    return w > 11 ? w : 11;
  endfunction
  function automatic cmd_e decode(input logic act_n, input logic ras_n, input logic cas_n, input logic we_n);
    if (!act_n) return ACT;
    case ({ras_n, cas_n, we_n})
      3'b101: return RD;
      3'b100: return WR;
      3'b010: return PRE;
      3'b001: return REF;
      3'b000: return MRS;
      default: return NOP;
    endcase
  endfunction
endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: read-data shift pipeline; entries are inserted at depth PIPE_D-CL so each keeps the latency it was issued with
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_t,
  input  logic              reset_n,
  input  logic              i_en,
  input  logic              i_push,
  input  logic [2:0]        i_cl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  logic [PIPE_D-1:0] r_vld;
  logic [DATA_W-1:0] r_dat [PIPE_D];
  logic [2:0]        w_slot;
  assign w_slot = 3'(PIPE_D) - i_cl;
  always_ff @(posedge clk_t) begin
    if (!reset_n) begin
      r_vld   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_en) begin
      o_valid <= r_vld[PIPE_D-1];
      o_data  <= r_vld[PIPE_D-1] ? r_dat[PIPE_D-1] : '0;
      r_vld   <= {r_vld[PIPE_D-2:0], 1'b0};
      for (int i = PIPE_D - 1; i > 0; i--) r_dat[i] <= r_dat[i-1];
      if (i_push) begin
        r_vld[w_slot] <= 1'b1;
        r_dat[w_slot] <= i_data;
      end
    end
  end
endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: command-decoding RAM controller with per-bank row tracking, tRCD/tRFC checks and CAS-latency read return
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int BA_W   = BA_W_DEF,
  parameter int ROW_W  = ROW_W_DEF,
  parameter int COL_W  = COL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CL_DEF = CL_DEF_DEF,
  parameter int TRCD   = TRCD_DEF,
  parameter int TRFC   = TRFC_DEF,
  parameter int ADDR_W = addr_w(ROW_W, COL_W)
) (
  input  logic                 clk_t,
  input  logic                 reset_n,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 act_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 we_n,
  input  logic [BA_W-1:0]      ba,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    dq_in,
  output logic [DATA_W-1:0]    dq_out,
  output logic                 dq_valid,
  output logic                 cmd_err,
  output logic [2**BA_W-1:0]   bank_open
);
  localparam int NB = 2**BA_W;
  localparam int IW = BA_W + ROW_W + COL_W;
  logic [ROW_W-1:0]  r_row [NB];
  logic [3:0]        r_rcd [NB];
  logic [3:0]        r_rfc;
  logic [2:0]        r_cl;
  logic [DATA_W-1:0] r_mem [2**IW];
  cmd_e              w_cmd;
  logic              w_err;
  logic              w_rd;
  logic              w_wr;
  logic [IW-1:0]     w_idx;
  logic              w_unused;
  assign w_unused = &{1'b0, addr};
  assign w_cmd = (cke && !cs_n) ? decode(act_n, ras_n, cas_n, we_n) : NOP;
  assign w_idx = {ba, r_row[ba], addr[COL_W-1:0]};
  assign w_err = (w_cmd != NOP && r_rfc != '0)
              || (w_cmd == ACT && bank_open[ba])
              || ((w_cmd == RD || w_cmd == WR) && (!bank_open[ba] || r_rcd[ba] != '0))
              || ((w_cmd == REF || w_cmd == MRS) && bank_open != '0);
  assign w_rd = w_cmd == RD && !w_err;
  assign w_wr = w_cmd == WR && !w_err && reset_n;
  always_ff @(posedge clk_t) begin
    if (!reset_n) begin
      bank_open <= '0;
      cmd_err   <= 1'b0;
      r_cl      <= 3'(CL_DEF);
      r_rfc     <= '0;
      for (int b = 0; b < NB; b++) r_rcd[b] <= '0;
    end else if (cke) begin
      cmd_err <= w_err;
      if (r_rfc != '0) r_rfc <= r_rfc - 4'd1;
      for (int b = 0; b < NB; b++) if (r_rcd[b] != '0) r_rcd[b] <= r_rcd[b] - 4'd1;
      if (!w_err) begin
        case (w_cmd)
          ACT: begin
            bank_open[ba] <= 1'b1;
            r_row[ba]     <= addr[ROW_W-1:0];
            r_rcd[ba]     <= 4'(TRCD - 1);
          end
          PRE: if (addr[10]) bank_open <= '0; else bank_open[ba] <= 1'b0;
          REF: r_rfc <= 4'(TRFC - 1);
          MRS: r_cl <= 3'(addr[1:0]) + 3'd2;
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge clk_t) if (w_wr) r_mem[w_idx] <= dq_in;
  ram_rd_pipe #(.DATA_W(DATA_W)) u_pipe (
    .clk_t  (clk_t),
    .reset_n(reset_n),
    .i_en   (cke),
    .i_push (w_rd),
    .i_cl   (r_cl),
    .i_data (r_mem[w_idx]),
    .o_valid(dq_valid),
    .o_data (dq_out)
  );
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed and randomized scoreboard bench for ram_ctrl against a behavioural command model
module tb_ram_ctrl;
  localparam int TRCD = 2;
  localparam int TRFC = 4;
  localparam int CL_DEF = 3;
  localparam logic [3:0] C_ACT = 4'b0111, C_RD = 4'b1101, C_WR = 4'b1100, C_PRE = 4'b1010;
  localparam logic [3:0] C_REF = 4'b1001, C_MRS = 4'b1000, C_NOP = 4'b1111;
  logic clk_t = 1'b0;
  logic reset_n, cke, cs_n, act_n, ras_n, cas_n, we_n;
  logic [1:0] ba;
  logic [10:0] addr;
  logic [7:0] dq_in, dq_out;
  logic dq_valid, cmd_err;
  logic [3:0] bank_open;
  typedef struct {
    int due;
    logic [7:0] data;
    bit known;
  } rd_t;
  rd_t rq[$];
  int eq[$];
  int checks = 0, errors = 0, etick = 0;
  bit [3:0] m_open;
  int m_row[4], m_act[4], m_ref_free, m_cl;
  logic [7:0] m_mem[int];

  ram_ctrl #(.BA_W(2), .ROW_W(4), .COL_W(4), .DATA_W(8), .CL_DEF(CL_DEF), .TRCD(TRCD), .TRFC(TRFC)) dut (
    .clk_t(clk_t), .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr), .dq_in(dq_in), .dq_out(dq_out),
    .dq_valid(dq_valid), .cmd_err(cmd_err), .bank_open(bank_open)
  );

  always #5 clk_t = ~clk_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, got, exp, etick);
    end
  endtask

  task automatic drive(input bit en, input bit cs, input logic [3:0] code, input int b, input int a, input logic [7:0] d);
    bit err, busy;
    int key;
    rd_t r;
    @(negedge clk_t);
    cke = en;
    cs_n = !cs;
    {act_n, ras_n, cas_n, we_n} = code;
    ba = 2'(b);
    addr = 11'(a);
    dq_in = d;
    if (!en) return;
    etick++;
    if (!cs) return;
    busy = etick < m_ref_free;
    key = b * 256 + m_row[b] * 16 + (a % 16);
    err = 1'b0;
    if (!code[3]) begin
      err = busy || m_open[b];
      if (!err) begin
        m_open[b] = 1'b1;
        m_row[b] = a % 16;
        m_act[b] = etick;
      end
    end else begin
      case (code[2:0])
        3'b101, 3'b100: begin
          err = busy || !m_open[b] || etick < m_act[b] + TRCD;
          if (!err && code[0]) begin
            r.due = etick + m_cl;
            r.known = m_mem.exists(key);
            r.data = r.known ? m_mem[key] : 8'h00;
            rq.push_back(r);
          end
          if (!err && !code[0]) m_mem[key] = d;
        end
        3'b010: begin
          err = busy;
          if (!err) begin
            if (a[10]) m_open = '0;
            else m_open[b] = 1'b0;
          end
        end
        3'b001: begin
          err = busy || m_open != 0;
          if (!err) m_ref_free = etick + TRFC;
        end
        3'b000: begin
          err = busy || m_open != 0;
          if (!err) m_cl = (a % 4) + 2;
        end
        default: ;
      endcase
    end
    if (err) eq.push_back(etick);
  endtask

  task automatic cmd(input logic [3:0] code, input int b = 0, input int a = 0, input logic [7:0] d = 8'h00);
    drive(1'b1, 1'b1, code, b, a, d);
  endtask

  task automatic nop(input int n);
    repeat (n) drive(1'b1, 1'b0, C_NOP, 0, 0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_t);
    reset_n = 1'b0;
    cke = 1'b1;
    cs_n = 1'b1;
    {act_n, ras_n, cas_n, we_n} = C_NOP;
    rq.delete();
    eq.delete();
    m_open = '0;
    m_cl = CL_DEF;
    m_ref_free = 0;
    repeat (n) @(negedge clk_t);
    check("rst_dq_out", 32'(dq_out), 32'h0);
    check("rst_dq_valid", 32'(dq_valid), 32'h0);
    check("rst_cmd_err", 32'(cmd_err), 32'h0);
    check("rst_bank_open", 32'(bank_open), 32'h0);
    reset_n = 1'b1;
    etick++;
  endtask

  initial begin
    bit en, exp_v, exp_e;
    rd_t r;
    forever begin
      @(posedge clk_t);
      en = cke && reset_n;
      #1;
      if (en) begin
        exp_v = rq.size() > 0 && rq[0].due == etick;
        check("dq_valid", 32'(dq_valid), 32'(exp_v));
        if (exp_v) begin
          r = rq.pop_front();
          if (r.known) check("dq_out", 32'(dq_out), 32'(r.data));
        end
        exp_e = eq.size() > 0 && eq[0] == etick;
        if (exp_e) void'(eq.pop_front());
        check("cmd_err", 32'(cmd_err), 32'(exp_e));
        check("bank_open", 32'(bank_open), 32'(m_open));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    cke = 1'b1;
    cs_n = 1'b1;
    {act_n, ras_n, cas_n, we_n} = C_NOP;
    ba = '0;
    addr = '0;
    dq_in = '0;
    m_cl = CL_DEF;
    do_reset(2);
    cmd(C_ACT, 1, 3); nop(1); cmd(C_WR, 1, 5, 8'hA5); cmd(C_RD, 1, 5); nop(4);
    check("t1_bank_open", 32'(bank_open), 32'h2);
    cmd(C_ACT, 2, 7); cmd(C_RD, 2, 1); nop(5);
    cmd(C_PRE, 0, 1 << 10); cmd(C_MRS, 0, 2); cmd(C_ACT, 0, 1); nop(1);
    cmd(C_WR, 0, 5, 8'h5A); cmd(C_RD, 0, 5); nop(6);
    cmd(C_REF); cmd(C_PRE, 0, 0); cmd(C_REF); cmd(C_ACT, 0, 2); nop(2); cmd(C_ACT, 0, 2); nop(1);
    for (int i = 0; i < 4; i++) cmd(C_WR, 0, i, 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) cmd(C_RD, 0, i);
    nop(6);
    cmd(C_RD, 0, 1);
    repeat (3) drive(1'b0, 1'b0, C_NOP, 0, 0, 8'h00);
    nop(6);
    cmd(C_RD, 0, 2); nop(1); do_reset(2); nop(6);
    cmd(C_ACT, 0, 2); nop(1); cmd(C_WR, 0, 7, 8'h77); cmd(C_RD, 0, 7); cmd(C_RD, 0, 0); nop(5);
    cmd(C_RD, 0, 3); cmd(C_PRE, 0, 1 << 10); cmd(C_MRS, 0, 3); cmd(C_ACT, 0, 2); nop(1); cmd(C_RD, 0, 0); nop(7);
    for (int i = 0; i < 800; i++) begin
      int p;
      logic [3:0] code;
      p = $urandom_range(99);
      code = p < 25 ? C_RD : p < 40 ? C_WR : p < 55 ? C_ACT : p < 65 ? C_PRE :
             p < 70 ? C_REF : p < 73 ? C_MRS : 4'($urandom);
      drive($urandom_range(9) != 0, $urandom_range(7) != 0, code, $urandom_range(3),
            $urandom_range(2047), 8'($urandom));
      if (i == 400) do_reset(1);
    end
    nop(10);
    check("rd_queue_drained", 32'(rq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

DDR-style command-decoding RAM controller with integrated storage. It sits behind the `ram_interface` bus, driven by the verification environment (or a host-side PHY). It samples chip-select/command pins on each enabled rising edge of `clk_t`, tracks per-bank open rows, enforces basic timing, and performs reads and writes on an internal array. Read data returns after a programmable CAS latency.

## Interface
Parameters:
- `BA_W`, default 2: bank address width (4 banks).
- `ROW_W`, default 4: row address width.
- `COL_W`, default 4: column address width.
- `DATA_W`, default 8: data width.
- `CL_DEF`, default 3: CAS latency after reset (legal 2..5).
- `TRCD`, default 2: minimum cycles from ACT to RD/WR on the same bank.
- `TRFC`, default 4: refresh busy cycles.

Ports (clock and reset first):
- `clk_t` in 1: the single clock; all logic on its rising edge. Complement `clk_c` is bus-only and unused by this block.
- `reset_n` in 1: synchronous, active-low reset.
- `cke` in 1: clock enable; when low, all state holds and commands are ignored.
- `cs_n` in 1: chip select, active low.
- `act_n` in 1: activate, active low.
- `ras_n`, `cas_n`, `we_n` in 1 each: command code.
- `ba` in BA_W: bank address.
- `addr` in max(ROW_W, COL_W+1, 11): row, or column in the low bits; bit 10 is the precharge-all flag.
- `dq_in` in DATA_W: write data, sampled with the WRITE command.
- `dq_out` out DATA_W: read data.
- `dq_valid` out 1: `dq_out` valid this cycle.
- `cmd_err` out 1: one-cycle pulse on an illegal command.
- `bank_open` out 2^BA_W: per-bank open flag.

## Operation
- A command is decoded only when `cke`=1 and `cs_n`=0; otherwise it is a NOP.
- `act_n`=0 → ACTIVATE: opens `ba` with row `addr[ROW_W-1:0]` and starts that bank's tRCD counter.
- With `act_n`=1, the code {ras_n,cas_n,we_n} selects:
  - 111 NOP.
  - 101 READ: reads array[ba][open_row][addr[COL_W-1:0]] at issue time and enters it into the latency pipeline.
  - 100 WRITE: writes `dq_in` to the same location in the same cycle.
  - 010 PRECHARGE: closes `ba`, or all banks if `addr[10]`=1.
  - 001 REFRESH: legal only with all banks closed; controller is busy for TRFC cycles.
  - 000 MODE REGISTER SET: legal only with all banks closed; sets CL = `addr[1:0]`+2.
  - Other codes: NOP.
- Illegal commands pulse `cmd_err` for one cycle and have no other effect:
  - ACT to an open bank.
  - RD/WR to a closed bank, or before TRCD has elapsed.
  - REF/MRS with any bank open.
  - Any non-NOP command while refresh is busy.
- Precharge of an already-closed bank is legal, with no effect.
- Array contents are not cleared by reset.

## Timing
- Reset state: `dq_out`=0, `dq_valid`=0, `cmd_err`=0, `bank_open`=0, CL=`CL_DEF`, refresh idle, read pipeline flushed.
- Reset asserted mid-read discards pending data.
- READ issued at edge N → `dq_valid`=1 with data during the cycle after edge N+CL, for exactly one cycle.
- Back-to-back READs every cycle are supported, producing continuous `dq_valid`.
- A WRITE issued while an earlier READ to the same address is in the pipeline does not alter that read's data.
- A WRITE followed by a READ on the next cycle returns the new data.
- `bank_open` updates on the edge the command is sampled.
- tRCD: RD/WR is legal at edge ACT+TRCD or later.
- `cmd_err` asserts on the edge after the offending command.
- `cke` low freezes pipeline, counters and outputs; the pipeline resumes when `cke` returns high.
- An MRS changing CL while reads are pending takes effect only for later reads.

## Structure
- Package `ram_pkg` holds:
  - enum `cmd_e` {NOP, ACT, RD, WR, PRE, REF, MRS}.
  - Command-pin decode function.
  - Default parameter constants.
- One sub-module is natural: `ram_rd_pipe`, a variable-latency read-data shift pipeline, depth 5, tapped by CL.
- Bank tracking is a small per-bank register file.
- The storage array is plain inferred memory.

## Test plan
- Reset, ACT bank 1 row 3, wait 2, WRITE col 5 data 0xA5, READ col 5 → `dq_out`=0xA5 with `dq_valid` 3 cycles after the READ; `bank_open`=4'b0010.
- READ issued 1 cycle after ACT (TRCD=2) → `cmd_err` pulse, no `dq_valid`.
- PRE all (`addr[10]`=1), MRS `addr[1:0]`=2, ACT, READ → data arrives with CL=4.
- REF with bank 0 open → `cmd_err`. Then PRE, REF, and ACT one cycle later → `cmd_err`; ACT after TRFC cycles is accepted.
- Four consecutive READs of cols 0–3 (preloaded 0x10..0x13) → four consecutive `dq_valid` cycles, values in order.
- `cke` low for 3 cycles with a READ pending → output delayed by 3 cycles; `reset_n` low mid-read → `dq_valid` never asserts and all outputs are 0.
